// File: rtl/core_mul_sched_pkg.sv
// Shared core micro-architecture types for the multiply scheduler.
//   word_t        : datapath word
//   mul_op        : operands and mode bits for one multiply request
//   sched_state_e : scheduler FSM state
package core_mul_sched_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c_hi;
        word_t c_lo;
        logic  long_mul;
        logic  add;
        logic  sig;
    } mul_op;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } sched_state_e;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

endpackage

// File: rtl/core_mul_sched_if.sv
// Bus between the issue lanes, the scheduler and the shared core_mul.
//   Lane side : req_*/op_* in, gnt_*/done_* out, q_hi/q_lo result, flush, busy
//   Mul side  : mul_* operands, start_mul out; mul_ready, mul_q_hi/lo in
// slave  : the scheduler view
// master : the dispatch / core_mul view
interface core_mul_sched_if;
    import core_mul_sched_pkg::*;

    logic  req_a, req_b;
    mul_op op_a, op_b;
    logic  gnt_a, gnt_b;
    logic  done_a, done_b;
    word_t q_hi, q_lo;
    logic  flush;
    logic  busy;
    word_t mul_a, mul_b, mul_c_hi, mul_c_lo;
    logic  mul_long, mul_add, mul_signed;
    logic  start_mul;
    logic  mul_ready;
    word_t mul_q_hi, mul_q_lo;

    modport slave (
        input  req_a, req_b, op_a, op_b, flush, mul_ready, mul_q_hi, mul_q_lo,
        output gnt_a, gnt_b, done_a, done_b, q_hi, q_lo, busy,
               mul_a, mul_b, mul_c_hi, mul_c_lo, mul_long, mul_add, mul_signed,
               start_mul
    );

    modport master (
        output req_a, req_b, op_a, op_b, flush, mul_ready, mul_q_hi, mul_q_lo,
        input  gnt_a, gnt_b, done_a, done_b, q_hi, q_lo, busy,
               mul_a, mul_b, mul_c_hi, mul_c_lo, mul_long, mul_add, mul_signed,
               start_mul
    );

endinterface

// File: rtl/core_mul_sched_rr_arb2.sv
// Two-request arbiter with a last-grant pointer.
//   clk, rst_n     : clock, async active-low reset
//   en             : grant allowed this cycle
//   req_a, req_b   : requests
//   gnt_a, gnt_b   : one-hot (or zero) combinational grant
// FAIR=1 alternates on contention; FAIR=0 always favours A.
module core_rr_arb2 #(
    parameter bit FAIR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // 1: lane B was granted last. Reset value makes A win the first tie.
    logic last_b_q, last_b_d;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                if (FAIR && !last_b_q) gnt_b = 1'b1;
                else                   gnt_a = 1'b1;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_comb begin
        last_b_d = last_b_q;
        if (gnt_a)      last_b_d = 1'b0;
        else if (gnt_b) last_b_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_b_q <= 1'b1;
        else        last_b_q <= last_b_d;
    end

endmodule

// File: rtl/core_mul_sched.sv
// Schedules multiply requests from two issue lanes onto one shared core_mul.
//   clk, rst_n : clock, async active-low reset (core_mul shares this reset)
//   bus        : lane handshakes, result, flush/busy and core_mul drive
// Flow: IDLE -(grant)-> ISSUE (start_mul) -> BUSY -(mul_ready)-> IDLE (done).
// A flush diverts ISSUE/BUSY to DRAIN, which swallows the result.
module core_mul_sched
    import core_mul_sched_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    core_mul_sched_if.slave   bus
);

    sched_state_e state_q, state_d;
    mul_op        op_q, op_d;
    logic         owner_q, owner_d;
    word_t        q_hi_q, q_hi_d, q_lo_q, q_lo_d;
    logic         done_a_q, done_a_d, done_b_q, done_b_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;

    logic arb_en, gnt_a, gnt_b;

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign arb_en = (state_q == IDLE) && !bus.flush && rst_n;

    core_rr_arb2 #(.FAIR(FAIR)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req_a (bus.req_a),
        .req_b (bus.req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        owner_d  = owner_q;
        q_hi_d   = q_hi_q;
        q_lo_d   = q_lo_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // mul_ready is meaningless here and deliberately ignored.
                if (gnt_a || gnt_b) begin
                    op_d    = gnt_a ? bus.op_a : bus.op_b;
                    owner_d = gnt_a ? LANE_A : LANE_B;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = bus.flush ? DRAIN : BUSY;
            BUSY: begin
                if (bus.mul_ready) begin
                    state_d = IDLE;
                    if (!bus.flush) begin
                        q_hi_d   = bus.mul_q_hi;
                        q_lo_d   = bus.mul_q_lo;
                        done_a_d = (owner_q == LANE_A);
                        done_b_d = (owner_q == LANE_B);
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (bus.mul_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            owner_q  <= LANE_A;
            q_hi_q   <= '0;
            q_lo_q   <= '0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            owner_q  <= owner_d;
            q_hi_q   <= q_hi_d;
            q_lo_q   <= q_lo_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt_a      = gnt_a;
    assign bus.gnt_b      = gnt_b;
    assign bus.done_a     = done_a_q;
    assign bus.done_b     = done_b_q;
    assign bus.q_hi       = q_hi_q;
    assign bus.q_lo       = q_lo_q;
    assign bus.busy       = busy_q;
    assign bus.start_mul  = start_q;
    // Operands stay on the core_mul inputs until the next grant reloads them.
    assign bus.mul_a      = op_q.a;
    assign bus.mul_b      = op_q.b;
    assign bus.mul_c_hi   = op_q.c_hi;
    assign bus.mul_c_lo   = op_q.c_lo;
    assign bus.mul_long   = op_q.long_mul;
    assign bus.mul_add    = op_q.add;
    assign bus.mul_signed = op_q.sig;

endmodule
